// File: rtl/axis2adi_pkg.sv
// Shared types and constants for the AXI-Stream to DAC transmit path.
// Control and status encodings match the ADC capture path.
package axis2adi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREFILL = 2'd1,
        ST_RUN     = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [31:0] CTRL_ABORT = 32'd0;
    localparam logic [31:0] CTRL_START = 32'd1;

    localparam int STAT_RUNNING   = 0;
    localparam int STAT_DONE      = 1;
    localparam int STAT_UNF       = 2;
    localparam int STAT_TLAST_ERR = 3;

    // TLAST must be high exactly on the beat that completes the packet.
    function automatic logic tlast_bad(input logic        tlast,
                                       input logic [31:0] cnt_in,
                                       input logic [31:0] nb,
                                       input logic [31:0] len);
        return tlast != ((cnt_in + nb) == len);
    endfunction

endpackage

// File: rtl/axis2adi_fifo.sv
// Synchronous show-ahead FIFO with wrap-bit pointers; flush empties it
// in one cycle. Pushes when full and pops when empty are ignored.
module axis2adi_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Status flags derive only from the registered pointers.
    always_comb begin
        full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
        empty     = (r_wr_ptr == r_rd_ptr);
        level     = r_wr_ptr - r_rd_ptr;
        dout      = r_mem[r_rd_ptr[AW-1:0]];
        w_push_ok = push && !full;
        w_pop_ok  = pop && !empty;
    end

    // Pointer update; flush and reset both return to empty.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/axis2adi_conv.sv
// AXI-Stream packet to DAC sample converter with prefill, underflow and
// TLAST checking. Define AXIS2ADI_HOLD_LAST_EN to repeat the last sample on underflow.
module axis2adi_conv
    import axis2adi_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_NUM_BYTES = 8,
    parameter int FIFO_DEPTH               = 4,
    parameter int PREFILL                  = 2
) (
    input  logic                                    AXIS_ACLK,
    input  logic                                    AXIS_ARESET,
    input  logic                                    S_AXIS_TVALID,
    input  logic [C_S_AXIS_TDATA_NUM_BYTES*8-1:0]   S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_NUM_BYTES-1:0]     S_AXIS_TSTRB,
    input  logic                                    S_AXIS_TLAST,
    output logic                                    S_AXIS_TREADY,
    output logic [C_S_AXIS_TDATA_NUM_BYTES*8-1:0]   ddata,
    output logic                                    dvalid,
    input  logic                                    drd,
    output logic                                    unf,
    input  logic [31:0]                             ctrl,
    input  logic [31:0]                             num_bytes,
    output logic [31:0]                             stat
);
    localparam int          W           = C_S_AXIS_TDATA_NUM_BYTES * 8;
    localparam int          AW          = $clog2(FIFO_DEPTH);
    localparam logic [31:0] NB_INC      = 32'(C_S_AXIS_TDATA_NUM_BYTES);
    localparam logic [AW:0] PREFILL_LVL = (AW+1)'(PREFILL);

    state_t       r_state;
    state_t       w_state_nxt;
    logic [31:0]  r_len;
    logic [31:0]  r_cnt_in;
    logic [31:0]  r_cnt_out;
    logic [W-1:0] r_ddata;
    logic         r_dvalid;
    logic         r_unf;
    logic         r_unf_sticky;
    logic         r_tlast_err;

    logic         w_abort;
    logic         w_start;
    logic         w_active;
    logic         w_tready;
    logic         w_push;
    logic         w_pop;
    logic         w_full;
    logic         w_empty;
    logic [AW:0]  w_level;
    logic [W-1:0] w_head;
    logic         w_unused_tstrb;

    assign w_unused_tstrb = ^S_AXIS_TSTRB;

    axis2adi_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (AXIS_ACLK),
        .rst   (AXIS_ARESET),
        .flush (w_abort),
        .push  (w_push),
        .pop   (w_pop),
        .din   (S_AXIS_TDATA),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

    // Handshake qualifiers; an abort cycle discards any beat and any pop.
    always_comb begin
        w_abort  = (ctrl == CTRL_ABORT);
        w_start  = (ctrl == CTRL_START);
        w_active = (r_state == ST_PREFILL) || (r_state == ST_RUN);
        w_tready = w_active && !w_full && (r_cnt_in < r_len);
        w_push   = S_AXIS_TVALID && w_tready && !w_abort;
        w_pop    = (r_state == ST_RUN) && drd && !w_empty && !w_abort;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) w_state_nxt = ST_PREFILL;
                    else         w_state_nxt = ST_IDLE;
                end
                ST_PREFILL: begin
                    if ((w_level >= PREFILL_LVL) || (r_cnt_in == r_len)) w_state_nxt = ST_RUN;
                    else                                                  w_state_nxt = ST_PREFILL;
                end
                ST_RUN: begin
                    if (w_pop && ((r_cnt_out + NB_INC) == r_len)) w_state_nxt = ST_DONE;
                    else                                          w_state_nxt = ST_RUN;
                end
                ST_DONE: w_state_nxt = ST_DONE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) r_state <= ST_IDLE;
        else             r_state <= w_state_nxt;
    end

    // Counters, sticky flags and the registered sample output.
    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET || w_abort) begin
            r_len        <= 32'd0;
            r_cnt_in     <= 32'd0;
            r_cnt_out    <= 32'd0;
            r_ddata      <= '0;
            r_dvalid     <= 1'b0;
            r_unf        <= 1'b0;
            r_unf_sticky <= 1'b0;
            r_tlast_err  <= 1'b0;
        end else begin
            r_dvalid <= 1'b0;
            r_unf    <= 1'b0;
            if ((r_state == ST_IDLE) && w_start) begin
                r_len        <= num_bytes;
                r_cnt_in     <= 32'd0;
                r_cnt_out    <= 32'd0;
                r_unf_sticky <= 1'b0;
                r_tlast_err  <= 1'b0;
            end
            if (w_push) begin
                r_cnt_in <= r_cnt_in + NB_INC;
                if (tlast_bad(S_AXIS_TLAST, r_cnt_in, NB_INC, r_len)) r_tlast_err <= 1'b1;
            end
            if ((r_state == ST_RUN) && drd) begin
                if (!w_empty) begin
                    r_ddata   <= w_head;
                    r_dvalid  <= 1'b1;
                    r_cnt_out <= r_cnt_out + NB_INC;
                end else begin
                    r_unf        <= 1'b1;
                    r_unf_sticky <= 1'b1;
`ifdef AXIS2ADI_HOLD_LAST_EN
                    // r_ddata already holds the last delivered sample (or 0).
                    r_ddata      <= r_ddata;
`else
                    r_ddata      <= '0;
`endif
                end
            end
        end
    end

    // Output mapping from registered state.
    always_comb begin
        S_AXIS_TREADY        = w_tready;
        ddata                = r_ddata;
        dvalid               = r_dvalid;
        unf                  = r_unf;
        stat                 = 32'd0;
        stat[STAT_RUNNING]   = w_active;
        stat[STAT_DONE]      = (r_state == ST_DONE);
        stat[STAT_UNF]       = r_unf_sticky;
        stat[STAT_TLAST_ERR] = r_tlast_err;
    end

endmodule

// File: tb/tb_axis2adi_conv.sv
// Randomised and directed bench for axis2adi_conv against a queue-based
// behavioural model, plus literal expectations from the test plan.
module tb_axis2adi_conv;
    localparam int NB    = 8;
    localparam int DEPTH = 4;
    localparam int PF    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        tvalid;
    logic [63:0] tdata;
    logic [7:0]  tstrb;
    logic        tlast;
    logic        tready;
    logic [63:0] ddata;
    logic        dvalid;
    logic        drd;
    logic        unf;
    logic [31:0] ctrl;
    logic [31:0] num_bytes;
    logic [31:0] stat;

    always #5 clk = ~clk;

    axis2adi_conv #(
        .C_S_AXIS_TDATA_NUM_BYTES (NB),
        .FIFO_DEPTH               (DEPTH),
        .PREFILL                  (PF)
    ) dut (
        .AXIS_ACLK     (clk),
        .AXIS_ARESET   (rst),
        .S_AXIS_TVALID (tvalid),
        .S_AXIS_TDATA  (tdata),
        .S_AXIS_TSTRB  (tstrb),
        .S_AXIS_TLAST  (tlast),
        .S_AXIS_TREADY (tready),
        .ddata         (ddata),
        .dvalid        (dvalid),
        .drd           (drd),
        .unf           (unf),
        .ctrl          (ctrl),
        .num_bytes     (num_bytes),
        .stat          (stat)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 prefill, 2 run, 3 done
    int          m_ph;
    logic [63:0] mq[$];
    logic [31:0] m_len, m_cin, m_cout;
    bit          m_terr, m_unfs, m_dvalid, m_unf;
    logic [63:0] m_ddata;
    bit          m_rdy;

    function automatic bit model_ready();
        return (m_ph == 1 || m_ph == 2) && (mq.size() < DEPTH) && (m_cin < m_len);
    endfunction

    always @(posedge clk) begin
        m_rdy = model_ready();
        m_unf = 1'b0;
        if (rst || ctrl == 32'd0) begin
            m_ph = 0; mq.delete(); m_len = 0; m_cin = 0; m_cout = 0;
            m_terr = 0; m_unfs = 0; m_dvalid = 0; m_ddata = 64'd0;
        end else begin
            m_dvalid = 1'b0;
            if (m_ph == 0) begin
                if (ctrl == 32'd1) begin
                    m_ph = 1; m_len = num_bytes; m_cin = 0; m_cout = 0; m_terr = 0; m_unfs = 0;
                end
            end else if (m_ph == 1) begin
                if (mq.size() >= PF || m_cin == m_len) m_ph = 2;
            end else if (m_ph == 2) begin
                if (drd) begin
                    if (mq.size() > 0) begin
                        m_ddata  = mq.pop_front();
                        m_dvalid = 1'b1;
                        m_cout   = m_cout + NB;
                        if (m_cout == m_len) m_ph = 3;
                    end else begin
                        m_unf  = 1'b1;
                        m_unfs = 1'b1;
`ifndef AXIS2ADI_HOLD_LAST_EN
                        m_ddata = 64'd0;
`endif
                    end
                end
            end
            if (m_rdy && tvalid) begin
                mq.push_back(tdata);
                if (tlast != (m_cin + NB == m_len)) m_terr = 1'b1;
                m_cin = m_cin + NB;
            end
        end
    end

    // Cycle-by-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("tready", {63'd0, tready}, {63'd0, model_ready()});
            check("ddata", ddata, m_ddata);
            check("dvalid", {63'd0, dvalid}, {63'd0, m_dvalid});
            check("unf", {63'd0, unf}, {63'd0, m_unf});
            check("stat", {32'd0, stat},
                  {32'd0, 28'd0, m_terr, m_unfs, (m_ph == 3), (m_ph == 1 || m_ph == 2)});
        end
    end

    // ---------------- stimulus ----------------
    logic [63:0] beats [16];
    logic [63:0] dq[$];
    int          nbeats, tlast_at, bi, unf_cnt;
    bit          first_unf_seen;
    logic [63:0] first_unf_ddata;

    task automatic step(input bit want_v, input bit want_d);
        bit hs;
        tvalid = want_v && (bi < nbeats);
        tdata  = (bi < nbeats) ? beats[bi] : 64'd0;
        tlast  = (bi == tlast_at);
        tstrb  = 8'($urandom);
        drd    = want_d;
        hs     = tvalid && tready && (ctrl != 32'd0);
        @(posedge clk);
        #2;
        if (hs) bi++;
        if (dvalid) dq.push_back(ddata);
        if (unf) begin
            unf_cnt++;
            if (!first_unf_seen) begin
                first_unf_seen  = 1'b1;
                first_unf_ddata = ddata;
            end
        end
    endtask

    task automatic start(input int len, input int n, input int tl);
        nbeats = n; tlast_at = tl; bi = 0; unf_cnt = 0;
        dq.delete(); first_unf_seen = 1'b0; first_unf_ddata = 64'd0;
        num_bytes = 32'(len);
        ctrl = 32'd1;
    endtask

    task automatic run_to_done(input int pv, input int pd, input int bound);
        int k = 0;
        while (!stat[1] && k < bound) begin
            step($urandom_range(99) < pv, $urandom_range(99) < pd);
            k++;
        end
        check("done_within_bound", {63'd0, stat[1]}, 64'd1);
    endtask

    task automatic finish_pkt();
        ctrl = 32'd0;
        step(1'b0, 1'b0);
    endtask

    task automatic seq_beats();
        for (int i = 0; i < 16; i++) beats[i] = 64'(17 * (i + 1));
    endtask

    initial begin
        rst = 1'b1; tvalid = 1'b0; tdata = 64'd0; tstrb = 8'd0; tlast = 1'b0;
        drd = 1'b0; ctrl = 32'd0; num_bytes = 32'd0;
        nbeats = 0; tlast_at = -1; bi = 0; unf_cnt = 0;
        first_unf_seen = 1'b0; first_unf_ddata = 64'd0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_stat", {32'd0, stat}, 64'd0);
        check("reset_tready", {63'd0, tready}, 64'd0);
        check("reset_ddata", ddata, 64'd0);
        check("reset_dvalid", {63'd0, dvalid}, 64'd0);

        // Nominal
        seq_beats();
        start(32, 4, 3);
        run_to_done(100, 100, 50);
        check("nom_count", 64'(dq.size()), 64'd4);
        check("nom_first", dq[0], 64'h11);
        check("nom_last", dq[3], 64'h44);
        check("nom_stat", {32'd0, stat}, 64'h2);
        check("nom_no_unf", 64'(unf_cnt), 64'd0);
        finish_pkt();

        // Underflow then resume
        seq_beats();
        start(64, 8, 7);
        for (int i = 0; i < 12; i++) step(bi < 3, 1'b1);
        check("unf_seen", {63'd0, first_unf_seen}, 64'd1);
`ifdef AXIS2ADI_HOLD_LAST_EN
        check("unf_ddata", first_unf_ddata, 64'h33);
`else
        check("unf_ddata", first_unf_ddata, 64'h0);
`endif
        check("unf_stat_bit2", {63'd0, stat[2]}, 64'd1);
        run_to_done(100, 100, 100);
        check("unf_final_stat", {32'd0, stat}, 64'h6);
        check("unf_count_out", 64'(dq.size()), 64'd8);
        for (int i = 0; i < 8; i++) check("unf_data", dq[i], 64'(17 * (i + 1)));
        finish_pkt();

        // TLAST error on beat 2
        seq_beats();
        start(32, 4, 1);
        run_to_done(100, 100, 50);
        check("tlast_stat", {32'd0, stat}, 64'hA);
        check("tlast_count", 64'(dq.size()), 64'd4);
        finish_pkt();

        // Backpressure
        seq_beats();
        start(64, 8, 7);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        check("bp_accepted", 64'(bi), 64'd4);
        check("bp_tready_low", {63'd0, tready}, 64'd0);
        step(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        check("bp_one_more", 64'(bi), 64'd5);
        check("bp_delivered", 64'(dq.size()), 64'd1);
        run_to_done(100, 100, 100);
        check("bp_stat", {32'd0, stat}, 64'h2);
        finish_pkt();

        // Abort after two samples, then restart with fresh data
        seq_beats();
        start(64, 8, 7);
        for (int i = 0; i < 40 && dq.size() < 2; i++) step(1'b1, 1'b1);
        ctrl = 32'd0;
        step(1'b0, 1'b0);
        check("abort_stat", {32'd0, stat}, 64'd0);
        check("abort_tready", {63'd0, tready}, 64'd0);
        check("abort_dvalid", {63'd0, dvalid}, 64'd0);
        check("abort_ddata", ddata, 64'd0);
        for (int i = 0; i < 4; i++) beats[i] = {$urandom, $urandom};
        start(32, 4, 3);
        run_to_done(100, 100, 50);
        check("restart_count", 64'(dq.size()), 64'd4);
        check("restart_first", dq[0], beats[0]);
        finish_pkt();

        // Reset mid-RUN
        seq_beats();
        start(64, 8, 7);
        for (int i = 0; i < 40 && dq.size() < 1; i++) step(1'b1, 1'b1);
        rst = 1'b1; ctrl = 32'd0;
        step(1'b0, 1'b0);
        rst = 1'b0;
        check("rst_stat", {32'd0, stat}, 64'd0);
        check("rst_tready", {63'd0, tready}, 64'd0);
        check("rst_ddata", ddata, 64'd0);
        check("rst_dvalid", {63'd0, dvalid}, 64'd0);
        check("rst_unf", {63'd0, unf}, 64'd0);
        seq_beats();
        start(32, 4, 3);
        run_to_done(100, 100, 50);
        check("rst_nom_first", dq[0], 64'h11);
        check("rst_nom_stat", {32'd0, stat}, 64'h2);
        finish_pkt();

        // Randomised packets
        for (int p = 0; p < 12; p++) begin
            int n;
            n = $urandom_range(1, 12);
            for (int i = 0; i < 16; i++) beats[i] = {$urandom, $urandom};
            start(n * NB, n, ($urandom_range(3) == 0) ? int'($urandom_range(0, n - 1)) : n - 1);
            run_to_done($urandom_range(30, 100), $urandom_range(30, 100), 800);
            check("rnd_count", 64'(dq.size()), 64'(n));
            finish_pkt();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
